// File: rtl/dac_pkg.sv
// Shared DAC-bus types and constants for the MD+ audio output stage.
// MDP_I2S_LJ_EN selects left-justified serial framing instead of standard I2S.
package dac_pkg;

  localparam int PH_BITS     = 9;
  localparam int FRAME_TICKS = 512;
  localparam int SLOT_BITS   = 16;

  typedef struct packed {
    logic               clk;
    logic [PH_BITS-1:0] phase;
    logic               next_sample;
  } dac_bus_t;

  // Bit carried by a given BCLK slot of one channel half.
  function automatic logic serial_bit(input logic [SLOT_BITS-1:0] word, input logic [4:0] slot);
    logic [4:0] idx;
`ifdef MDP_I2S_LJ_EN
    idx = 5'd15 - slot;
    return (slot < 5'd16) ? word[idx[3:0]] : 1'b0;
`else
    idx = 5'd16 - slot;
    return (slot >= 5'd1 && slot <= 5'd16) ? word[idx[3:0]] : 1'b0;
`endif
  endfunction

endpackage

// File: rtl/mdp_i2s_nco.sv
// Fractional NCO: accumulates rate*2^PH_BITS per clk against CLK_HZ.
// tick is the combinational wrap strobe for this clk; the top registers it.
module mdp_i2s_nco #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int PH_BITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] rate,
  output logic        tick
);

  localparam logic [31:0] LIMIT = 32'(CLK_HZ);

  logic [31:0] acc;
  logic [31:0] inc;
  logic [31:0] sum;

  assign inc  = 32'(rate) << PH_BITS;
  assign sum  = acc + inc;
  assign tick = (sum >= LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      acc <= tick ? (sum - LIMIT) : sum;
    end
  end

endmodule

// File: rtl/mdp_i2s_tx.sv
// I2S transmitter with NCO-derived frame timing; tick/phase/sdat are registered together.
// Build option MDP_I2S_LJ_EN switches to left-justified framing (MSB on the LRCK edge).
module mdp_i2s_tx
  import dac_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 snd_on,
  input  logic [16:0]          rate,
  input  logic signed [15:0]   snd_l,
  input  logic signed [15:0]   snd_r,
  output logic                 tick,
  output logic [PH_BITS-1:0]   phase,
  output logic                 next_sample,
  output logic                 i2s_mclk,
  output logic                 i2s_bclk,
  output logic                 i2s_lrck,
  output logic                 i2s_sdat
);

  logic                 wrap;
  dac_bus_t             bus;
  logic [15:0]          word_l;
  logic [15:0]          word_r;
  logic [15:0]          cur_l;
  logic [15:0]          cur_r;
  logic [15:0]          cur_word;
  logic [PH_BITS-1:0]   phase_nxt;
  logic                 sdat_nxt;
  logic                 sdat;

  mdp_i2s_nco #(
    .CLK_HZ  (CLK_HZ),
    .PH_BITS (PH_BITS)
  ) u_nco (
    .clk  (clk),
    .rst  (rst),
    .rate (rate),
    .tick (wrap)
  );

  // Bypass the latch so a wrap landing in the capture cycle still sends the new words.
  assign cur_l     = bus.next_sample ? snd_l : word_l;
  assign cur_r     = bus.next_sample ? snd_r : word_r;
  assign phase_nxt = bus.phase + 1'b1;
  assign cur_word  = phase_nxt[PH_BITS-1] ? cur_r : cur_l;
  assign sdat_nxt  = snd_on & serial_bit(cur_word, phase_nxt[7:3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus    <= '0;
      word_l <= '0;
      word_r <= '0;
      sdat   <= 1'b0;
    end else begin
      bus.clk         <= wrap;
      bus.next_sample <= wrap && (phase_nxt == PH_BITS'(FRAME_TICKS - 1));
      if (wrap) begin
        bus.phase <= phase_nxt;
        if (phase_nxt[2:0] == 3'd0) begin
          sdat <= sdat_nxt;
        end
      end
      if (bus.next_sample) begin
        word_l <= snd_l;
        word_r <= snd_r;
      end
    end
  end

  assign tick        = bus.clk;
  assign phase       = bus.phase;
  assign next_sample = bus.next_sample;
  assign i2s_mclk    = bus.phase[0];
  assign i2s_bclk    = bus.phase[2];
  assign i2s_lrck    = bus.phase[PH_BITS-1];
  assign i2s_sdat    = sdat;

endmodule

// File: tb/tb_mdp_i2s_tx.sv
// Directed bench for mdp_i2s_tx: NCO rates, serial framing, reset and rate-stop corners.
module tb_mdp_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snd_on = 1'b0;
  logic [16:0] rate = '0;
  logic [15:0] snd_l = '0;
  logic [15:0] snd_r = '0;
  logic        tick;
  logic [8:0]  phase;
  logic        next_sample;
  logic        i2s_mclk;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdat;

  mdp_i2s_tx #(.CLK_HZ(50_000_000)) dut (
    .clk         (clk),
    .rst         (rst),
    .snd_on      (snd_on),
    .rate        (rate),
    .snd_l       (snd_l),
    .snd_r       (snd_r),
    .tick        (tick),
    .phase       (phase),
    .next_sample (next_sample),
    .i2s_mclk    (i2s_mclk),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrck    (i2s_lrck),
    .i2s_sdat    (i2s_sdat)
  );

  always #5 clk = ~clk;

`ifdef MDP_I2S_LJ_EN
  localparam int OFF = 0;
`else
  localparam int OFF = 1;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] fbits;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        on;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wait_ns();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (next_sample) return;
    end
    timeout("wait_next_sample");
  endtask

  // Deserialise on BCLK rising (phase[2:0]==4) until the frame closes at next_sample.
  task automatic collect_frame();
    fbits = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tick && phase[2:0] == 3'd4) fbits[phase[8:3]] = i2s_sdat;
      if (next_sample) return;
    end
    timeout("collect_frame");
  endtask

  task automatic decode(output logic [15:0] gl, output logic [15:0] gr, output int stray);
    stray = 0;
    for (int k = 0; k < 16; k++) begin
      gl[15-k] = fbits[OFF+k];
      gr[15-k] = fbits[32+OFF+k];
    end
    for (int s = 0; s < 32; s++) begin
      if (s < OFF || s > OFF + 15) stray += int'(fbits[s]) + int'(fbits[32+s]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] gl;
    logic [15:0] gr;
    int stray;
    int nticks;
    int nns;
    int bad_iv;
    longint cyc;
    longint first_ns;
    longint last_ns;
    real exp_sum;
    logic [8:0] ph0;
    logic sd0;
    logic lr0;
    int changes;
    bit seen;

    vecs[0] = '{16'h8001, 16'h7FFE, 1'b1, 16'h8001, 16'h7FFE};
    vecs[1] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 16'hFFFF};
    vecs[2] = '{16'hA5C3, 16'h1234, 1'b1, 16'hA5C3, 16'h1234};
    vecs[3] = '{16'h8001, 16'h7FFE, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{16'h0001, 16'h8000, 1'b1, 16'h0001, 16'h8000};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_tick", 32'(tick), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_next_sample", 32'(next_sample), 0);
    check("rst_mclk", 32'(i2s_mclk), 0);
    check("rst_bclk", 32'(i2s_bclk), 0);
    check("rst_lrck", 32'(i2s_lrck), 0);
    check("rst_sdat", 32'(i2s_sdat), 0);

    // 44.1 kHz tick and frame cadence from a clean accumulator
    rate = 17'd44100;
    snd_on = 1'b1;
    rst = 1'b0;
    nticks = 0; nns = 0; bad_iv = 0; first_ns = -1; last_ns = -1;
    for (cyc = 1; cyc <= 30000; cyc++) begin
      @(negedge clk);
      if (tick) nticks++;
      if (next_sample) begin
        nns++;
        if (last_ns >= 0 && (cyc - last_ns < 1133 || cyc - last_ns > 1134)) bad_iv++;
        if (first_ns < 0) first_ns = cyc;
        last_ns = cyc;
      end
    end
    check_rng("tick_count_44k1", nticks, 13546, 13548);
    check_rng("ns_count_44k1", nns, 25, 27);
    check("ns_interval_out_of_range", 32'(bad_iv), 0);
    exp_sum = (nns - 1) * 50000000.0 / 44100.0;
    check_rng("ns_interval_sum", last_ns - first_ns, longint'($ceil(exp_sum - 1.0)), longint'($floor(exp_sum + 1.0)));

    // Serial framing vectors
    rate = 17'd96000;
    foreach (vecs[v]) begin
      snd_l = vecs[v].l;
      snd_r = vecs[v].r;
      snd_on = vecs[v].on;
      wait_ns();
      @(negedge clk);
      snd_l = ~vecs[v].l;
      snd_r = ~vecs[v].r;
      collect_frame();
      decode(gl, gr, stray);
      check($sformatf("vec%0d_left", v), 32'(gl), 32'(vecs[v].exp_l));
      check($sformatf("vec%0d_right", v), 32'(gr), 32'(vecs[v].exp_r));
      check($sformatf("vec%0d_idle_slots", v), 32'(stray), 0);
    end

    // Reset in the middle of the right half
    snd_on = 1'b1;
    rate = 17'd44100;
    snd_l = 16'h0000;
    snd_r = 16'hFFFF;
    wait_ns();
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (phase == 9'd300) seen = 1'b1;
    end
    if (!seen) timeout("wait_phase_300");
    check("pre_rst_lrck", 32'(i2s_lrck), 1);
    check("pre_rst_sdat", 32'(i2s_sdat), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_phase", 32'(phase), 0);
    check("midrst_sdat", 32'(i2s_sdat), 0);
    check("midrst_lrck", 32'(i2s_lrck), 0);
    check("midrst_tick", 32'(tick), 0);
    rst = 1'b0;
    seen = 1'b0;
    nticks = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (tick) begin
        seen = 1'b1;
        nticks = i;
      end
    end
    check("first_tick_latency", 32'(nticks), 3);
    check("first_tick_phase", 32'(phase), 1);

    // Rate stop then restart at 48 kHz
    repeat (700) @(negedge clk);
    rate = 17'd0;
    @(negedge clk);
    ph0 = phase; sd0 = i2s_sdat; lr0 = i2s_lrck;
    nticks = 0; changes = 0;
    repeat (100) begin
      @(negedge clk);
      if (tick) nticks++;
      if (phase !== ph0 || i2s_sdat !== sd0 || i2s_lrck !== lr0) changes++;
    end
    check("stop_ticks", 32'(nticks), 0);
    check("stop_outputs_changed", 32'(changes), 0);
    rate = 17'd48000;
    nticks = 0;
    repeat (20000) begin
      @(negedge clk);
      if (tick) nticks++;
    end
    check_rng("tick_count_48k", nticks, 9829, 9831);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
